// File: rtl/gray_codec_pkg.sv
`default_nettype none
// ============================================================================
//  gray_codec_pkg : mode encodings, chunk sizing and reference conversions
//  Revision: 1.0
// ============================================================================
package gray_codec_pkg;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    // Number of Gray->binary bits each stage resolves.
    function automatic int chunk_bits(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic logic [63:0] bin2gray_f(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [63:0] gray2bin_f(input logic [63:0] g);
        logic [63:0] b;
        b[63] = g[63];
        for (int i = 62; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_codec_if.sv
`default_nettype none
// ============================================================================
//  gray_codec_if : producer/consumer handshake bundle of the Gray codec
//  Revision: 1.0
// ============================================================================
interface gray_codec_if #(
    parameter int WIDTH = 8
);
    logic             strobe;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [WIDTH-1:0] out_data;

    modport master (
        output strobe, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data
    );

    modport slave (
        input  strobe, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data
    );
endinterface
`default_nettype wire

// File: rtl/gray_codec_stage.sv
`default_nettype none
// ============================================================================
//  gray_codec_stage : one elastic pipeline stage of the Gray codec
//  Revision: 1.0
// ============================================================================
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 2,
    parameter int STAGE_IDX = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             in_valid,
    output logic                  in_ready,
    input  wire logic             in_mode,
    input  wire logic [WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  wire logic             out_ready,
    output logic                  out_mode,
    output logic [WIDTH-1:0]      out_data
);

    localparam int c_chunk  = chunk_bits(WIDTH, STAGES);
    localparam int c_hi     = WIDTH - 1 - (STAGE_IDX - 1) * c_chunk;
    localparam int c_lo_raw = WIDTH - STAGE_IDX * c_chunk;
    localparam int c_lo     = (c_lo_raw < 0) ? 0 : c_lo_raw;

    logic             r_valid;
    logic             r_mode;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_next;
    logic             w_load;

    // Data word: bits above this stage's window are already binary, bits
    // below are still raw Gray; bit i+1 is therefore the carry for bit i.
    always_comb begin
        w_next = in_data;
        if (in_mode == MODE_B2G) begin
            if (STAGE_IDX == 1) begin
                w_next = in_data ^ (in_data >> 1);
            end
        end else begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                if (i <= c_hi && i >= c_lo) begin
                    w_next[i] = in_data[i] ^ w_next[i+1];
                end
            end
        end
    end

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_mode  <= in_mode;
            r_data  <= w_next;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_mode  = r_mode;
    assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/gray_codec.sv
`default_nettype none
// ============================================================================
//  gray_codec : pipelined binary<->Gray converter with valid/ready handshake
//  Revision: 1.0
// ============================================================================
module gray_codec #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    gray_codec_if.slave bus
);

    // Each generate block owns its link signals so the ready chain runs
    // through distinct nets from the output back to in_ready.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_in_valid;
        logic             w_in_ready;
        logic             w_in_mode;
        logic [WIDTH-1:0] w_in_data;
        logic             w_out_valid;
        logic             w_out_ready;
        logic             w_out_mode;
        logic [WIDTH-1:0] w_out_data;

        if (k == 0) begin : g_head
            assign w_in_valid   = bus.strobe;
            assign w_in_mode    = bus.in_mode;
            assign w_in_data    = bus.in_data;
            assign bus.in_ready = w_in_ready;
        end else begin : g_link
            assign w_in_valid = g_stage[k-1].w_out_valid;
            assign w_in_mode  = g_stage[k-1].w_out_mode;
            assign w_in_data  = g_stage[k-1].w_out_data;
        end

        if (k == STAGES - 1) begin : g_tail
            assign w_out_ready   = bus.out_ready;
            assign bus.out_valid = w_out_valid;
            assign bus.out_mode  = w_out_mode;
            assign bus.out_data  = w_out_data;
        end else begin : g_fwd
            assign w_out_ready = g_stage[k+1].w_in_ready;
        end

        gray_codec_stage #(
            .WIDTH     (WIDTH),
            .STAGES    (STAGES),
            .STAGE_IDX (k + 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (w_in_valid),
            .in_ready  (w_in_ready),
            .in_mode   (w_in_mode),
            .in_data   (w_in_data),
            .out_valid (w_out_valid),
            .out_ready (w_out_ready),
            .out_mode  (w_out_mode),
            .out_data  (w_out_data)
        );
    end

endmodule
`default_nettype wire
